gj_axis_rcv_framer: RTL and testbench
=====================================

// Module: gj_axis_rcv_framer
// PURPOSE
//  Converts the per-byte UART receive stream into AXI-Stream frames with backpressure.
//  Frame boundaries come from an inter-byte gap timeout or a byte-count limit; tlast sits on the true last byte.
//  A one-entry hold stage delays each byte until its last-ness is known; an output register carries tready stalls.
//  Sits between the UART byte receiver and downstream AXIS packet consumers.
// PARAMETERS
//  DATA_W   8   width of in_tdata / out_tdata
//  CNT_W    16  width of max_bytes, max_gap, byte and gap counters
// PORTS
//  clk           in   1       clock
//  rst           in   1       asynchronous, active-high reset
//  clk_en        in   1       gap-timer tick (baud-derived strobe)
//  max_bytes     in   CNT_W   frame byte limit; 0 = no limit
//  max_gap       in   CNT_W   gap timeout in clk_en ticks
//  in_tvalid     in   1       one-cycle pulse: received byte valid
//  in_tdata      in   DATA_W  received byte
//  in_tuser      in   1       1 = byte had a parity/stop error
//  out_tvalid    out  1       AXIS valid
//  out_tready    in   1       AXIS ready
//  out_tdata     out  DATA_W  AXIS data
//  out_tlast     out  1       last byte of frame
//  out_tuser     out  1       frame-error flag; meaningful only with out_tlast
//  overflow      out  1       one-cycle pulse when an input byte is dropped
// BEHAVIOUR
//  Reset: all outputs 0; hold/output registers empty; byte_cnt=0; gap_cnt=0; err_flag=0; flush_pend=0.
//  Stages: H (hold: valid, data); O (output register: valid, data, last, user); O drives the out_* ports.
//  Beat transfer: out_tvalid & out_tready. O may be reloaded in the cycle it transfers (no bubble).
//  Accepted byte (in_tvalid & !in_tuser):
//   - Goes into H; byte_cnt+1; gap_cnt<=max_gap.
//   - If H was already full, the old H moves to O with last=0.
//  Error byte (in_tvalid & in_tuser): discarded; err_flag<=1; gap_cnt reloads; byte_cnt unchanged.
//  Flush:
//   - Triggers: H valid & gap_cnt==0 (timeout); or H valid & max_bytes!=0 & byte_cnt==max_bytes (limit).
//   - Effect: H moves to O with last=1, user=err_flag; then byte_cnt<=0, err_flag<=0.
//   - If O cannot load, flush_pend holds until it can.
//  Gap timer: decrements on clk_en while H valid & gap_cnt!=0. max_gap=0 times out on the cycle after the load.
//  O load: allowed when O empty or transferring this cycle.
//   - H->O move needed while O blocked and a new byte arrives: incoming byte dropped.
//   - Drop effects: overflow pulses; err_flag<=1; H, byte_cnt and gap_cnt unchanged.
//  Simultaneous events:
//   - Byte arrival and timeout in same cycle: the arrival wins, no timeout.
//   - Byte arrival with limit reached: the limit flush of old H takes priority.
//     H gets the new byte as the first of the next frame; byte_cnt<=1.
//  Error byte with H empty: err_flag is kept for the next frame.
//  Latency: last byte appears on out_* 1 cycle after its timeout/limit flush condition, if O is free.
//  Mid-frame reset: all state cleared; any partial frame is lost with no tlast.
//  max_bytes/max_gap are sampled live; change them only while idle.
//  Widths: byte_cnt saturates at all-ones; byte_cnt > max_bytes after a live change flushes immediately.
// TESTING
//  1. max_gap=4, tready=1; bytes 11,22,33 close together, then silence:
//     11,22 last=0; 33 last=1 after 4 clk_en ticks; user=0.
//  2. max_bytes=3, continuous bytes A0..A5:
//     two frames of 3, tlast on A2 and A5, with no timeout needed.
//  3. Byte 44 with in_tuser=1 mid-frame among 01,02,03:
//     44 absent from output; frame 01,02,03 ends tlast=1, tuser=1.
//  4. tready=0 held; 3 bytes in:
//     overflow pulses once on the 3rd byte; frame ends tuser=1.
//     After tready=1, bytes 1,2 come out in order.
//  5. Timeout tick coinciding with a new byte arrival: no tlast on the held byte; frame continues.
//  6. rst asserted with H and O full:
//     out_tvalid=0 immediately; the next frame starts clean with user=0.

Source files
------------

// File: rtl/gj_axis_rcv_framer.sv
// UART byte stream to AXI-Stream framer.
// Frames close on gap timeout or byte limit.
module gj_axis_rcv_framer #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic [CNT_W-1:0]  max_bytes,
  input  logic [CNT_W-1:0]  max_gap,
  input  logic              in_tvalid,
  input  logic [DATA_W-1:0] in_tdata,
  input  logic              in_tuser,
  output logic              out_tvalid,
  input  logic              out_tready,
  output logic [DATA_W-1:0] out_tdata,
  output logic              out_tlast,
  output logic              out_tuser,
  output logic              overflow
);

  logic              h_vld_q, h_vld_d;
  logic [DATA_W-1:0] h_dat_q, h_dat_d;
  logic              o_vld_q, o_vld_d;
  logic [DATA_W-1:0] o_dat_q, o_dat_d;
  logic              o_last_q, o_last_d;
  logic              o_user_q, o_user_d;
  logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic [CNT_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic              err_q, err_d;
  logic              pend_q, pend_d;
  logic              ovf_q, ovf_d;

  logic             xfer;
  logic             o_free;
  logic             acc;
  logic             bad;
  logic             lim;
  logic             tmo;
  logic             fl;
  logic [CNT_W-1:0] cnt_inc;

  assign xfer   = o_vld_q & out_tready;
  assign o_free = ~o_vld_q | xfer;
  assign acc    = in_tvalid & ~in_tuser;
  assign bad    = in_tvalid & in_tuser;
  assign lim    = h_vld_q & (max_bytes != '0)
                & (byte_cnt_q >= max_bytes);
  // any arrival, good or bad, defers the timeout
  assign tmo    = h_vld_q & (gap_cnt_q == '0)
                & ~in_tvalid;
  assign fl     = h_vld_q & (pend_q | lim | tmo);
  assign cnt_inc = (&byte_cnt_q) ? byte_cnt_q
                 : byte_cnt_q + CNT_W'(1);

  always_comb begin
    h_vld_d    = h_vld_q;
    h_dat_d    = h_dat_q;
    o_vld_d    = o_vld_q;
    o_dat_d    = o_dat_q;
    o_last_d   = o_last_q;
    o_user_d   = o_user_q;
    byte_cnt_d = byte_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    err_d      = err_q;
    pend_d     = pend_q;
    ovf_d      = 1'b0;

    if (xfer) o_vld_d = 1'b0;

    if (fl) begin
      if (o_free) begin
        o_vld_d    = 1'b1;
        o_dat_d    = h_dat_q;
        o_last_d   = 1'b1;
        o_user_d   = err_q;
        h_vld_d    = 1'b0;
        byte_cnt_d = '0;
        err_d      = 1'b0;
        pend_d     = 1'b0;
      end else begin
        pend_d = 1'b1;
      end
    end

    if (acc) begin
      if (fl) begin
        if (o_free) begin
          h_vld_d    = 1'b1;
          h_dat_d    = in_tdata;
          byte_cnt_d = CNT_W'(1);
          gap_cnt_d  = max_gap;
        end else begin
          ovf_d = 1'b1;
          err_d = 1'b1;
        end
      end else if (h_vld_q) begin
        if (o_free) begin
          o_vld_d    = 1'b1;
          o_dat_d    = h_dat_q;
          o_last_d   = 1'b0;
          o_user_d   = 1'b0;
          h_dat_d    = in_tdata;
          byte_cnt_d = cnt_inc;
          gap_cnt_d  = max_gap;
        end else begin
          ovf_d = 1'b1;
          err_d = 1'b1;
        end
      end else begin
        h_vld_d    = 1'b1;
        h_dat_d    = in_tdata;
        byte_cnt_d = cnt_inc;
        gap_cnt_d  = max_gap;
      end
    end else if (bad) begin
      err_d     = 1'b1;
      gap_cnt_d = max_gap;
    end else if (clk_en & h_vld_q
                 & (gap_cnt_q != '0)) begin
      gap_cnt_d = gap_cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_vld_q    <= 1'b0;
      h_dat_q    <= '0;
      o_vld_q    <= 1'b0;
      o_dat_q    <= '0;
      o_last_q   <= 1'b0;
      o_user_q   <= 1'b0;
      byte_cnt_q <= '0;
      gap_cnt_q  <= '0;
      err_q      <= 1'b0;
      pend_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      h_vld_q    <= h_vld_d;
      h_dat_q    <= h_dat_d;
      o_vld_q    <= o_vld_d;
      o_dat_q    <= o_dat_d;
      o_last_q   <= o_last_d;
      o_user_q   <= o_user_d;
      byte_cnt_q <= byte_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      err_q      <= err_d;
      pend_q     <= pend_d;
      ovf_q      <= ovf_d;
    end
  end

  assign out_tvalid = o_vld_q;
  assign out_tdata  = o_dat_q;
  assign out_tlast  = o_last_q;
  assign out_tuser  = o_user_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_gj_axis_rcv_framer.sv
// Scoreboard bench for gj_axis_rcv_framer.
// Expected beats queued at stimulus time.
module tb_gj_axis_rcv_framer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clk_en = 1'b1;
  logic [15:0] max_bytes = '0;
  logic [15:0] max_gap = 16'd4;
  logic        in_tvalid = 1'b0;
  logic [7:0]  in_tdata = '0;
  logic        in_tuser = 1'b0;
  logic        out_tvalid;
  logic        out_tready = 1'b1;
  logic [7:0]  out_tdata;
  logic        out_tlast;
  logic        out_tuser;
  logic        overflow;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic       u;
  } beat_t;

  beat_t q[$];
  int    total = 0;
  int    bad = 0;
  int    ovf_cnt = 0;

  always #5 clk = ~clk;

  gj_axis_rcv_framer dut (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .max_bytes(max_bytes), .max_gap(max_gap),
    .in_tvalid(in_tvalid), .in_tdata(in_tdata),
    .in_tuser(in_tuser),
    .out_tvalid(out_tvalid),
    .out_tready(out_tready),
    .out_tdata(out_tdata), .out_tlast(out_tlast),
    .out_tuser(out_tuser), .overflow(overflow)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  task automatic expect_beat(input logic [7:0] d,
                             input logic l,
                             input logic u);
    beat_t b;
    b.d = d; b.l = l; b.u = u;
    q.push_back(b);
  endtask

  task automatic send(input logic [7:0] d,
                      input logic u);
    in_tvalid = 1'b1;
    in_tdata  = d;
    in_tuser  = u;
    @(posedge clk); #1;
    in_tvalid = 1'b0;
    in_tuser  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    chk(tag, q.size(), 0);
    idle(3);
  endtask

  always @(negedge clk) begin
    if (!rst && overflow) ovf_cnt++;
    if (!rst && out_tvalid && out_tready) begin
      if (q.size() == 0) begin
        chk("extra_beat", q.size(), 1);
      end else begin
        beat_t e;
        e = q.pop_front();
        chk("data", out_tdata, e.d);
        chk("last", out_tlast, e.l);
        chk("user", out_tuser, e.u);
      end
    end
  end

  initial begin
    #1;
    chk("rst_valid", out_tvalid, 0);
    chk("rst_last", out_tlast, 0);
    chk("rst_ovf", overflow, 0);
    idle(3);
    rst = 1'b0;
    idle(2);

    // 1: gap timeout closes the frame
    expect_beat(8'h11, 0, 0);
    expect_beat(8'h22, 0, 0);
    expect_beat(8'h33, 1, 0);
    send(8'h11, 0); send(8'h22, 0);
    send(8'h33, 0);
    drain("t1");

    // 2: byte limit, no timeout needed
    max_bytes = 16'd3;
    max_gap   = 16'd100;
    for (int i = 0; i < 6; i++)
      expect_beat(8'hA0 + 8'(i),
                  (i == 2 || i == 5), 0);
    for (int i = 0; i < 6; i++)
      send(8'hA0 + 8'(i), 0);
    drain("t2");
    max_bytes = '0;
    max_gap   = 16'd4;

    // 3: error byte mid-frame
    expect_beat(8'h01, 0, 0);
    expect_beat(8'h02, 0, 0);
    expect_beat(8'h03, 1, 1);
    send(8'h01, 0); send(8'h02, 0);
    send(8'h44, 1); send(8'h03, 0);
    drain("t3");

    // error with H empty carries to next frame
    send(8'h55, 1);
    idle(2);
    expect_beat(8'h09, 1, 1);
    send(8'h09, 0);
    drain("t3b");

    // 4: backpressure overflow
    ovf_cnt = 0;
    out_tready = 1'b0;
    expect_beat(8'h01, 0, 0);
    expect_beat(8'h02, 1, 1);
    send(8'h01, 0); send(8'h02, 0);
    send(8'h03, 0);
    idle(12);
    chk("ovf_once", ovf_cnt, 1);
    chk("stall_valid", out_tvalid, 1);
    out_tready = 1'b1;
    drain("t4");

    // 5: arrival on the timeout cycle
    max_gap = 16'd2;
    expect_beat(8'h61, 0, 0);
    expect_beat(8'h62, 1, 0);
    send(8'h61, 0);
    idle(2);
    send(8'h62, 0);
    drain("t5");
    max_gap = 16'd4;

    // 6: reset with H and O full
    out_tready = 1'b0;
    send(8'h77, 1);
    send(8'h05, 0); send(8'h06, 0);
    rst = 1'b1;
    #1;
    chk("rst_mid_valid", out_tvalid, 0);
    q.delete();
    idle(2);
    rst = 1'b0;
    out_tready = 1'b1;
    idle(2);
    expect_beat(8'h07, 0, 0);
    expect_beat(8'h08, 1, 0);
    send(8'h07, 0); send(8'h08, 0);
    drain("t6");

    chk("ovf_total", ovf_cnt, 1);
    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
